// File: rtl/bitstream_deframer.sv
// Serial-to-byte deframer: hunts for SYNC_WORD, then emits FRAME_BYTES MSB-first payload bytes.
// Define DEFRAMER_CHECKSUM_EN to receive and verify a trailing XOR checksum byte per frame.
module bitstream_deframer #(
    parameter logic [7:0] SYNC_WORD   = 8'hA5,
    parameter int         FRAME_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    input  logic       data_in_valid,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    output logic       frame_start,
    output logic       frame_end,
    output logic       frame_err,
    output logic       locked
);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;
    localparam logic [7:0] LAST_BYTE  = 8'(FRAME_BYTES - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] window_q, window_d;
    logic [3:0] fill_q, fill_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_out_valid_q, data_out_valid_d;
    logic       frame_start_q, frame_start_d;
    logic       frame_end_q, frame_end_d;
    logic       frame_err_q, frame_err_d;
    logic       locked_q, locked_d;

    logic [7:0] win_shift_s;
    logic [7:0] byte_shift_s;
    logic [3:0] fill_inc_s;

`ifdef DEFRAMER_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;

    function automatic logic [7:0] xor_accum(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d          = state_q;
        window_d         = window_q;
        fill_d           = fill_q;
        shift_d          = shift_q;
        bit_cnt_d        = bit_cnt_q;
        byte_cnt_d       = byte_cnt_q;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        frame_start_d    = 1'b0;
        frame_end_d      = 1'b0;
        frame_err_d      = 1'b0;
`ifdef DEFRAMER_CHECKSUM_EN
        xor_d            = xor_q;
`endif
        win_shift_s  = {window_q[6:0], data_in};
        byte_shift_s = {shift_q[6:0], data_in};
        fill_inc_s   = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;

        if (data_in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    window_d = win_shift_s;
                    fill_d   = fill_inc_s;
                    // fill saturates at 8 so stale bits from before HUNT can never complete a sync
                    if ((fill_inc_s == 4'd8) && (win_shift_s == SYNC_WORD)) begin
                        state_d    = ST_PAYLOAD;
                        shift_d    = 8'd0;
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = 8'd0;
`ifdef DEFRAMER_CHECKSUM_EN
                        xor_d      = 8'd0;
`endif
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_PAYLOAD: begin
                    shift_d   = byte_shift_s;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        data_out_d       = byte_shift_s;
                        data_out_valid_d = 1'b1;
                        frame_start_d    = (byte_cnt_q == 8'd0);
`ifdef DEFRAMER_CHECKSUM_EN
                        xor_d            = xor_accum(xor_q, byte_shift_s);
`endif
                        if (byte_cnt_q == LAST_BYTE) begin
`ifdef DEFRAMER_CHECKSUM_EN
                            state_d     = ST_CHECK;
`else
                            state_d     = ST_HUNT;
                            frame_end_d = 1'b1;
                            window_d    = 8'd0;
                            fill_d      = 4'd0;
`endif
                        end else begin
                            byte_cnt_d = byte_cnt_q + 8'd1;
                        end
                    end else begin
                        data_out_valid_d = 1'b0;
                    end
                end
                ST_CHECK: begin
`ifdef DEFRAMER_CHECKSUM_EN
                    shift_d   = byte_shift_s;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d     = ST_HUNT;
                        frame_end_d = 1'b1;
                        frame_err_d = (byte_shift_s != xor_q);
                        window_d    = 8'd0;
                        fill_d      = 4'd0;
                    end else begin
                        state_d = ST_CHECK;
                    end
`else
                    state_d  = ST_HUNT;
                    window_d = 8'd0;
                    fill_d   = 4'd0;
`endif
                end
                default: begin
                    state_d  = ST_HUNT;
                    window_d = 8'd0;
                    fill_d   = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        locked_d = (state_d != ST_HUNT);
    end

    // State and output registers, cleared asynchronously by active-low rst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_HUNT;
            window_q         <= 8'd0;
            fill_q           <= 4'd0;
            shift_q          <= 8'd0;
            bit_cnt_q        <= 3'd0;
            byte_cnt_q       <= 8'd0;
            data_out_q       <= 8'd0;
            data_out_valid_q <= 1'b0;
            frame_start_q    <= 1'b0;
            frame_end_q      <= 1'b0;
            frame_err_q      <= 1'b0;
            locked_q         <= 1'b0;
`ifdef DEFRAMER_CHECKSUM_EN
            xor_q            <= 8'd0;
`endif
        end else begin
            state_q          <= state_d;
            window_q         <= window_d;
            fill_q           <= fill_d;
            shift_q          <= shift_d;
            bit_cnt_q        <= bit_cnt_d;
            byte_cnt_q       <= byte_cnt_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            frame_start_q    <= frame_start_d;
            frame_end_q      <= frame_end_d;
            frame_err_q      <= frame_err_d;
            locked_q         <= locked_d;
`ifdef DEFRAMER_CHECKSUM_EN
            xor_q            <= xor_d;
`endif
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign frame_start    = frame_start_q;
    assign frame_end      = frame_end_q;
    assign frame_err      = frame_err_q;
    assign locked         = locked_q;

endmodule

// File: tb/tb_bitstream_deframer.sv
// Self-checking bench for bitstream_deframer: directed table, reset/back-to-back sequences and
// randomized streams checked cycle by cycle against a sync-search reference model.
module tb_bitstream_deframer;

    localparam int         FB   = 4;
    localparam int         MAXB = 4096;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_in;
    logic       data_in_valid;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       frame_start;
    logic       frame_end;
    logic       frame_err;
    logic       locked;

    bitstream_deframer #(.SYNC_WORD(SYNC), .FRAME_BYTES(FB)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_out(data_out), .data_out_valid(data_out_valid), .frame_start(frame_start),
        .frame_end(frame_end), .frame_err(frame_err), .locked(locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    bit         stream_b [MAXB];
    int         nbits;
    bit         e_dv [MAXB];
    bit         e_fs [MAXB];
    bit         e_fe [MAXB];
    bit         e_err [MAXB];
    bit         e_lock [MAXB];
    logic [7:0] e_data [MAXB];

    logic [7:0] cap_q [$];
    int         fs_cnt, fe_cnt, err_cnt;

    typedef struct {
        int          noise_len;
        logic [7:0]  noise;
        logic [31:0] pay;
        bit          corrupt;
        int          gap;
        logic [31:0] exp_bytes;
        bit          exp_err;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void push_bits(input logic [7:0] v, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            stream_b[nbits] = v[i];
            nbits++;
        end
    endfunction

    function automatic void push_frame(input logic [31:0] w, input bit corrupt);
        logic [7:0] ck;
        push_bits(SYNC, 8);
        for (int b = 3; b >= 0; b--) push_bits(w[b*8 +: 8], 8);
        ck = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0] ^ {7'd0, corrupt};
`ifdef DEFRAMER_CHECKSUM_EN
        push_bits(ck, 8);
`else
        if (ck == 8'd0) nbits = nbits + 0;
`endif
    endfunction

    function automatic logic [7:0] byte_at(input int p);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 8; i++) r = {r[6:0], stream_b[p + i]};
        return r;
    endfunction

    // Reference: search the whole bit array for each sync, then slice the frame out of it
    function automatic void build_model();
        int k, j, p, fin, last;
        bit done;
        logic [7:0] x;
        for (int m = 0; m < nbits; m++) begin
            e_dv[m] = 1'b0; e_fs[m] = 1'b0; e_fe[m] = 1'b0;
            e_err[m] = 1'b0; e_lock[m] = 1'b0; e_data[m] = 8'd0;
        end
        k = 0;
        done = 1'b0;
        while (!done && k < nbits) begin
            j = -1;
            for (int m = k + 7; m < nbits && j < 0; m++)
                if (byte_at(m - 7) == SYNC) j = m;
            if (j < 0) begin
                done = 1'b1;
            end else begin
                p = j + 1;
                x = 8'd0;
                fin = p + 8 * FB - 1;
`ifdef DEFRAMER_CHECKSUM_EN
                fin = fin + 8;
`endif
                for (int m = j; m <= fin && m < nbits; m++) e_lock[m] = (m != fin);
                for (int b = 0; b < FB; b++) begin
                    last = p + 8 * b + 7;
                    if (last < nbits) begin
                        e_dv[last]   = 1'b1;
                        e_data[last] = byte_at(p + 8 * b);
                        e_fs[last]   = (b == 0);
                        x = x ^ e_data[last];
                    end
                end
                if (fin < nbits) begin
                    e_fe[fin] = 1'b1;
`ifdef DEFRAMER_CHECKSUM_EN
                    e_err[fin] = (byte_at(fin - 7) != x);
`endif
                end
                k = fin + 1;
                if (fin >= nbits) done = 1'b1;
            end
        end
    endfunction

    task automatic tick_check(input int k, input bit sampled);
        logic [4:0] exp;
        logic       lk;
        @(posedge clk);
        #1;
        lk = (k >= 0) ? e_lock[k] : 1'b0;
        if (sampled) exp = {e_dv[k], e_fs[k], e_fe[k], e_err[k], lk};
        else         exp = {4'b0000, lk};
        chk("pulses_locked", 32'({data_out_valid, frame_start, frame_end, frame_err, locked}), 32'(exp));
        if (sampled && e_dv[k]) chk("data_out", 32'(data_out), 32'(e_data[k]));
        if (data_out_valid) cap_q.push_back(data_out);
        if (frame_start) fs_cnt++;
        if (frame_end)   fe_cnt++;
        if (frame_err)   err_cnt++;
    endtask

    task automatic apply_reset();
        data_in_valid = 1'b0;
        data_in       = 1'b0;
        rst           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            32'({data_out, data_out_valid, frame_start, frame_end, frame_err, locked}), 32'd0);
        rst = 1'b1;
    endtask

    task automatic run_stream(input bit do_reset, input int gap_mode);
        int idle;
        build_model();
        cap_q.delete();
        fs_cnt = 0; fe_cnt = 0; err_cnt = 0;
        if (do_reset) apply_reset();
        for (int k = 0; k < nbits; k++) begin
            idle = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 3));
            repeat (idle) begin
                data_in_valid = 1'b0;
                data_in       = 1'($urandom);
                tick_check(k - 1, 1'b0);
            end
            data_in_valid = 1'b1;
            data_in       = stream_b[k];
            tick_check(k, 1'b1);
        end
        data_in_valid = 1'b0;
        repeat (3) tick_check(nbits - 1, 1'b0);
    endtask

    task automatic chk_bytes(input string name, input logic [31:0] exp_w);
        logic [7:0] act;
        chk({name, "_count"}, 32'(cap_q.size()), 32'd4);
        for (int b = 0; b < 4; b++) begin
            if (b < cap_q.size()) act = cap_q[b];
            else act = 8'hxx;
            chk({name, "_byte"}, 32'(act), 32'(exp_w[(3 - b) * 8 +: 8]));
        end
    endtask

    initial begin
        vecs[0] = '{0, 8'h00, 32'h11223344, 1'b0, 0, 32'h11223344, 1'b0};
        vecs[1] = '{3, 8'h05, 32'hDEADBEEF, 1'b0, 0, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{0, 8'h00, 32'h11223344, 1'b0, 1, 32'h11223344, 1'b0};
`ifdef DEFRAMER_CHECKSUM_EN
        vecs[3] = '{0, 8'h00, 32'h11223344, 1'b1, 0, 32'h11223344, 1'b1};
`else
        vecs[3] = '{0, 8'h00, 32'h11223344, 1'b1, 0, 32'h11223344, 1'b0};
`endif
        vecs[4] = '{8, 8'hA4, 32'h5AC300FF, 1'b0, 2, 32'h5AC300FF, 1'b0};

        rst = 1'b0;
        data_in = 1'b0;
        data_in_valid = 1'b0;

        for (int v = 0; v < 5; v++) begin
            nbits = 0;
            push_bits(vecs[v].noise, vecs[v].noise_len);
            push_frame(vecs[v].pay, vecs[v].corrupt);
            run_stream(1'b1, vecs[v].gap);
            chk_bytes("table", vecs[v].exp_bytes);
            chk("table_fs_cnt", 32'(fs_cnt), 32'd1);
            chk("table_fe_cnt", 32'(fe_cnt), 32'd1);
            chk("table_err_cnt", 32'(err_cnt), 32'(vecs[v].exp_err));
        end

        // Reset in the middle of a frame: sync plus 12 payload bits, then a clean frame
        apply_reset();
        nbits = 0;
        push_bits(SYNC, 8);
        push_bits(8'h11, 8);
        push_bits(8'h0A, 4);
        for (int k = 0; k < nbits; k++) begin
            data_in_valid = 1'b1;
            data_in = stream_b[k];
            @(posedge clk);
            #1;
        end
        chk("midframe_locked", 32'(locked), 32'd1);
        data_in_valid = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("async_reset_outputs",
            32'({data_out, data_out_valid, frame_start, frame_end, frame_err, locked}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        nbits = 0;
        push_frame(32'h01020304, 1'b0);
        run_stream(1'b0, 0);
        chk_bytes("after_reset", 32'h01020304);
        chk("after_reset_fe_cnt", 32'(fe_cnt), 32'd1);

        // Back-to-back frames with no idle bits between them
        nbits = 0;
        push_frame(32'h11223344, 1'b0);
        push_frame(32'h55667788, 1'b0);
        run_stream(1'b1, 0);
        chk("b2b_count", 32'(cap_q.size()), 32'd8);
        chk("b2b_fs_cnt", 32'(fs_cnt), 32'd2);
        chk("b2b_fe_cnt", 32'(fe_cnt), 32'd2);
        if (cap_q.size() == 8) begin
            chk("b2b_first", 32'(cap_q[0]), 32'h11);
            chk("b2b_fifth", 32'(cap_q[4]), 32'h55);
            chk("b2b_last", 32'(cap_q[7]), 32'h88);
        end else begin
            chk("b2b_bytes_present", 32'(cap_q.size()), 32'd8);
        end

        // Randomized streams: noise, frames, occasional bad checksums, random gaps
        for (int r = 0; r < 6; r++) begin
            nbits = 0;
            repeat (8) begin
                push_bits(8'($urandom), int'($urandom_range(0, 8)));
                push_bits(8'($urandom), int'($urandom_range(0, 2)));
                push_frame($urandom, 1'($urandom_range(0, 1)));
            end
            run_stream(1'b1, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bitstream_deframer.md
# bitstream_deframer

Receive-side stage that consumes the serial output of the transmit serializer (`data_out`/`data_out_valid` pair) and turns it back into framed bytes. It hunts the bitstream for a sync byte, then assembles a fixed number of MSB-first payload bytes. Each payload byte is presented on a byte-wide valid-qualified output, with frame start/end markers for the packet layer downstream.

## Interface
- `SYNC_WORD`, 8'hA5, sync byte that opens every frame; matched MSB first.
- `FRAME_BYTES`, 4, payload bytes per frame; legal range 1..255.

- `clk` in 1 — sole clock; all logic on rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `data_in` in 1 — serial bit, MSB of each byte first.
- `data_in_valid` in 1 — `data_in` is sampled only on edges where this is high.
- `data_out` out 8 — assembled payload byte.
- `data_out_valid` out 1 — one-cycle pulse; `data_out` is valid.
- `frame_start` out 1 — pulse coincident with the first payload byte's `data_out_valid`.
- `frame_end` out 1 — pulse marking frame completion (see Configuration).
- `frame_err` out 1 — pulse with `frame_end` on checksum mismatch; tied 0 when the checksum is compiled out.
- `locked` out 1 — high from sync match until frame completion.

## Operation
- States:
  - HUNT: shift each valid bit into an 8-bit window; count fill up to 8. When fill = 8 and window == `SYNC_WORD` after the shift, go to PAYLOAD.
  - PAYLOAD: collect bits into a byte shift register with a 3-bit bit counter. On the 8th bit, emit the byte and increment the byte counter. After byte `FRAME_BYTES`-1, go to CHECK if the macro is defined, otherwise go to HUNT.
  - CHECK: collect 8 bits as the checksum byte, then go to HUNT.
- Entering HUNT clears the window and fill count. A sync must consist of 8 fresh bits, and payload bits never count toward the next sync.
- Sliding search: any bit offset is accepted, and noise before the sync is discarded.
- Cycles with `data_in_valid` low hold all state; gaps of any length are allowed between bits.
- No backpressure: the consumer must accept every `data_out_valid` pulse.
- `locked` = (state != HUNT).
- Reset mid-operation clears all state immediately: state to HUNT, counters to 0, outputs to 0. A partial byte or frame is dropped without `frame_end`.

## Timing
- Reset values: `data_out`=0, `data_out_valid`=0, `frame_start`=0, `frame_end`=0, `frame_err`=0, `locked`=0.
- All outputs are registered.
- `data_out_valid` is high for exactly the one cycle after the edge that samples a byte's 8th bit, so latency is 1 clk from the last bit.
- `data_out` holds its value until the next byte.
- `locked` rises one cycle after the edge sampling the sync's last bit. It falls one cycle after the edge sampling the frame's final bit: the last payload bit, or the last checksum bit when the macro is defined.
- A new sync bit may be accepted on the very next valid edge after the frame completes; back-to-back frames carry no idle requirement.
- Minimum bit spacing is 1 clk (`data_in_valid` held high continuously).

## Configuration
- `DEFRAMER_CHECKSUM_EN` defined:
  - Each frame carries one trailing checksum byte, equal to the XOR of all payload bytes. It is received in CHECK and never emitted on `data_out`.
  - `frame_end` pulses one cycle after the checksum's last bit.
  - `frame_err` pulses in that same cycle if the received checksum ≠ the running XOR.
- Not defined:
  - The CHECK state and XOR register are absent; `frame_err` is tied 0.
  - `frame_end` pulses together with the last payload byte's `data_out_valid`.

## Test plan
- Basic frame (macro off): continuous bits A5,11,22,33,44 → `data_out_valid` pulses with 11,22,33,44. `frame_start` fires with 11 and `frame_end` with 44. `locked` drops after the 44 byte.
- Misaligned search: bits 1,0,1, then A5,DE,AD,BE,EF → the three noise bits are ignored and bytes DE,AD,BE,EF are output.
- Valid gaps: same frame with `data_in_valid` toggling 1-0-0-1 between every bit → identical bytes, each pulse exactly 1 cycle wide.
- Checksum (macro on):
  - A5,11,22,33,44,44 → `frame_end`=1 and `frame_err`=0.
  - Trailing byte 45 instead → `frame_end`=1 and `frame_err`=1; the checksum byte never appears on `data_out`.
- Reset mid-frame: assert `rst`=0 after A5 plus 12 payload bits → all outputs 0 and `locked`=0. Following A5,01,02,03,04 → clean frame 01..04.
- Back-to-back: two frames with no gap (A5,…,A5,…) → 8 byte pulses and two `frame_start`/`frame_end` pairs.
